// File: rtl/uart_rx.sv
// 16x-oversampling UART receiver: recovers NB_DATA-bit frames LSB first, flags framing errors.
// Define UART_RX_PARITY_EN to add an even-parity bit (8E1) and drive o_parity_error.
module uart_rx #(
  parameter int unsigned NB_DATA         = 8,
  parameter int unsigned NB_STOP         = 1,
  parameter int unsigned NB_TICK_COUNTER = 4,
  parameter int unsigned NB_DATA_COUNTER = 3
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_tick,
  input  logic               i_data,
  output logic [NB_DATA-1:0] o_data,
  output logic               o_data_valid,
  output logic               o_frame_error,
  output logic               o_parity_error
);

  localparam logic [NB_TICK_COUNTER-1:0] LP_TICK_MID  =
    NB_TICK_COUNTER'((1 << NB_TICK_COUNTER) / 2 - 1);
  localparam logic [NB_TICK_COUNTER-1:0] LP_TICK_LAST = {NB_TICK_COUNTER{1'b1}};
  localparam logic [NB_DATA_COUNTER-1:0] LP_BIT_LAST  = NB_DATA_COUNTER'(NB_DATA - 1);
  localparam logic [0:0]                 LP_STOP_LAST = 1'(NB_STOP - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef UART_RX_PARITY_EN
    StParity,
`endif
    StStop,
    StBreak
  } state_e;

  state_e                     r_state,      w_state_next;
  logic [NB_TICK_COUNTER-1:0] r_tick_cnt,   w_tick_next;
  logic [NB_DATA_COUNTER-1:0] r_bit_cnt,    w_bit_next;
  logic [0:0]                 r_stop_cnt,   w_stop_next;
  logic [NB_DATA-1:0]         r_shift,      w_shift_next;
  logic                       r_ferr_pend,  w_ferr_pend_next;
  logic [NB_DATA-1:0]         r_data,       w_data_next;
  logic                       r_valid,      w_valid_next;
  logic                       r_frame_error, w_frame_error_next;
  logic                       w_ferr_now;
`ifdef UART_RX_PARITY_EN
  logic                       r_parity_bit,   w_parity_bit_next;
  logic                       r_parity_error, w_parity_error_next;
`endif

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_state        <= StIdle;
      r_tick_cnt     <= '0;
      r_bit_cnt      <= '0;
      r_stop_cnt     <= '0;
      r_shift        <= '0;
      r_ferr_pend    <= 1'b0;
      r_data         <= '0;
      r_valid        <= 1'b0;
      r_frame_error  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_parity_bit   <= 1'b0;
      r_parity_error <= 1'b0;
`endif
    end else begin
      r_state        <= w_state_next;
      r_tick_cnt     <= w_tick_next;
      r_bit_cnt      <= w_bit_next;
      r_stop_cnt     <= w_stop_next;
      r_shift        <= w_shift_next;
      r_ferr_pend    <= w_ferr_pend_next;
      r_data         <= w_data_next;
      r_valid        <= w_valid_next;
      r_frame_error  <= w_frame_error_next;
`ifdef UART_RX_PARITY_EN
      r_parity_bit   <= w_parity_bit_next;
      r_parity_error <= w_parity_error_next;
`endif
    end
  end

  always_comb begin
    w_state_next       = r_state;
    w_tick_next        = r_tick_cnt;
    w_bit_next         = r_bit_cnt;
    w_stop_next        = r_stop_cnt;
    w_shift_next       = r_shift;
    w_ferr_pend_next   = r_ferr_pend;
    w_data_next        = r_data;
    w_valid_next       = 1'b0;
    w_frame_error_next = r_frame_error;
    w_ferr_now         = r_ferr_pend | ~i_data;
`ifdef UART_RX_PARITY_EN
    w_parity_bit_next   = r_parity_bit;
    w_parity_error_next = r_parity_error;
`endif

    unique case (r_state)
      StIdle: begin
        w_tick_next = '0;
        if (!i_data) begin
          w_state_next     = StStart;
          w_bit_next       = '0;
          w_stop_next      = '0;
          w_ferr_pend_next = 1'b0;
        end
      end

      StStart: begin
        if (i_tick) begin
          if (r_tick_cnt == LP_TICK_MID) begin
            w_tick_next  = '0;
            // A line back high at mid-start-bit was a glitch, not a frame.
            w_state_next = i_data ? StIdle : StData;
          end else begin
            w_tick_next = r_tick_cnt + NB_TICK_COUNTER'(1);
          end
        end
      end

      StData: begin
        if (i_tick) begin
          if (r_tick_cnt == LP_TICK_LAST) begin
            w_tick_next  = '0;
            w_shift_next = {i_data, r_shift[NB_DATA-1:1]};
            if (r_bit_cnt == LP_BIT_LAST) begin
              w_bit_next = '0;
`ifdef UART_RX_PARITY_EN
              w_state_next = StParity;
`else
              w_state_next = StStop;
`endif
            end else begin
              w_bit_next = r_bit_cnt + NB_DATA_COUNTER'(1);
            end
          end else begin
            w_tick_next = r_tick_cnt + NB_TICK_COUNTER'(1);
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (i_tick) begin
          if (r_tick_cnt == LP_TICK_LAST) begin
            w_tick_next       = '0;
            w_parity_bit_next = i_data;
            w_state_next      = StStop;
          end else begin
            w_tick_next = r_tick_cnt + NB_TICK_COUNTER'(1);
          end
        end
      end
`endif

      StStop: begin
        if (i_tick) begin
          if (r_tick_cnt == LP_TICK_LAST) begin
            w_tick_next      = '0;
            w_ferr_pend_next = w_ferr_now;
            if (r_stop_cnt == LP_STOP_LAST) begin
              w_stop_next        = '0;
              w_data_next        = r_shift;
              w_valid_next       = 1'b1;
              w_frame_error_next = w_ferr_now;
`ifdef UART_RX_PARITY_EN
              w_parity_error_next = ^{r_shift, r_parity_bit};
`endif
              w_state_next = w_ferr_now ? StBreak : StIdle;
            end else begin
              w_stop_next = r_stop_cnt + 1'b1;
            end
          end else begin
            w_tick_next = r_tick_cnt + NB_TICK_COUNTER'(1);
          end
        end
      end

      StBreak: begin
        w_tick_next = '0;
        if (i_data) begin
          w_state_next = StIdle;
        end
      end

      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  assign o_data        = r_data;
  assign o_data_valid  = r_valid;
  assign o_frame_error = r_frame_error;
`ifdef UART_RX_PARITY_EN
  assign o_parity_error = r_parity_error;
`else
  assign o_parity_error = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: stimulus pushes expected bytes/flags/latency, monitor checks strobes.
module tb_uart_rx;

  localparam int NB_DATA   = 8;
  localparam int NB_STOP   = 1;
  localparam int TICK_DIV  = 4;
`ifdef UART_RX_PARITY_EN
  localparam int PAR_TICKS = 16;
`else
  localparam int PAR_TICKS = 0;
`endif
  // Ticks from START entry (start-bit falling edge) to the strobe cycle.
  localparam int LATENCY   = 8 + 16 * NB_DATA + PAR_TICKS + 16 * NB_STOP;

  logic               i_clock;
  logic               i_reset;
  logic               i_tick;
  logic               i_data;
  logic [NB_DATA-1:0] o_data;
  logic               o_data_valid;
  logic               o_frame_error;
  logic               o_parity_error;

  typedef struct {
    logic [7:0] data;
    logic       ferr;
    logic       perr;
    int         start;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   tick_cnt = 0;
  int   cyc      = 0;

  uart_rx #(
    .NB_DATA        (NB_DATA),
    .NB_STOP        (NB_STOP),
    .NB_TICK_COUNTER(4),
    .NB_DATA_COUNTER(3)
  ) dut (
    .i_clock       (i_clock),
    .i_reset       (i_reset),
    .i_tick        (i_tick),
    .i_data        (i_data),
    .o_data        (o_data),
    .o_data_valid  (o_data_valid),
    .o_frame_error (o_frame_error),
    .o_parity_error(o_parity_error)
  );

  initial begin
    i_clock = 1'b0;
    forever #5 i_clock = ~i_clock;
  end

  // Tick strobe: one clock in TICK_DIV, changed just after the edge.
  initial begin
    i_tick = 1'b0;
    forever begin
      @(posedge i_clock);
      #1;
      cyc++;
      i_tick = (cyc % TICK_DIV == 0);
    end
  end

  always @(posedge i_clock) begin
    if (i_tick) tick_cnt <= tick_cnt + 1;
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Returns 1 time unit after the edge carrying the n-th tick.
  task automatic wait_ticks(input int n);
    int k;
    k = 0;
    while (k < n) begin
      @(posedge i_clock);
      if (i_tick) k++;
    end
    if (n > 0) #1;
  endtask

  task automatic idle(input int n);
    i_data = 1'b1;
    wait_ticks(n);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_flip);
    exp_t e;
    i_data  = 1'b0;
    e.data  = b;
    e.ferr  = ~stop_bit;
`ifdef UART_RX_PARITY_EN
    e.perr  = par_flip;
`else
    e.perr  = 1'b0;
`endif
    e.start = tick_cnt;
    exp_q.push_back(e);
    wait_ticks(16);
    for (int i = 0; i < 8; i++) begin
      i_data = b[i];
      wait_ticks(16);
    end
`ifdef UART_RX_PARITY_EN
    i_data = (^b) ^ par_flip;
    wait_ticks(16);
`endif
    i_data = stop_bit;
    wait_ticks(16 * NB_STOP);
  endtask

  // Monitor: one pop per strobe cycle; a strobe with nothing expected is a failure.
  initial begin
    exp_t e;
    forever begin
      @(negedge i_clock);
      if (o_data_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("data", int'(o_data), int'(e.data));
          check("frame_error", int'(o_frame_error), int'(e.ferr));
          check("parity_error", int'(o_parity_error), int'(e.perr));
          check("latency_ticks", tick_cnt - e.start, LATENCY);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] b;
    i_reset = 1'b0;
    i_data  = 1'b1;
    repeat (4) @(posedge i_clock);
    #1;
    check("reset_data", int'(o_data), 0);
    check("reset_valid", int'(o_data_valid), 0);
    check("reset_frame_error", int'(o_frame_error), 0);
    check("reset_parity_error", int'(o_parity_error), 0);
    i_reset = 1'b1;
    idle(20);

    send_frame(8'hA5, 1'b1, 1'b0);
    idle(20);

    // Short low glitch: must not start a frame.
    i_data = 1'b0;
    wait_ticks(4);
    idle(30);
    send_frame(8'h3C, 1'b1, 1'b0);
    idle(10);

    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    idle(10);

    // Stop bit low then held low: one strobe with frame error, then silence.
    send_frame(8'h55, 1'b0, 1'b0);
    i_data = 1'b0;
    wait_ticks(40);
    idle(30);

    // Reset pulse during data bit 4 of 0xF0 (bit 4 is 1, so line is high at reset).
    b = 8'hF0;
    i_data = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 4; i++) begin
      i_data = b[i];
      wait_ticks(16);
    end
    i_data = b[4];
    wait_ticks(8);
    @(posedge i_clock);
    #1;
    i_reset = 1'b0;
    @(posedge i_clock);
    #1;
    i_reset = 1'b1;
    check("midreset_data", int'(o_data), 0);
    check("midreset_valid", int'(o_data_valid), 0);
    check("midreset_frame_error", int'(o_frame_error), 0);
    check("midreset_parity_error", int'(o_parity_error), 0);
    idle(40);

    send_frame(8'h81, 1'b1, 1'b0);
    idle(10);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h03, 1'b1, 1'b1);
    idle(10);
    send_frame(8'h03, 1'b1, 1'b0);
    idle(10);
`endif

    for (int n = 0; n < 6; n++) begin
      b = 8'($urandom);
      send_frame(b, 1'b1, 1'($urandom_range(0, 1)));
      idle($urandom_range(0, 20));
    end
    idle(40);

    check("pending_frames", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver for the UART datapath, the receive-side counterpart of `uart_tx`. Oversamples the incoming serial line at 16 ticks per bit using the shared `baudrate_generator` tick, recovers 8N1 frames (LSB first), and presents each byte with a one-cycle valid strobe. Its output feeds the byte-oriented interface logic that drives `uart_tx`. The block also flags framing errors and, optionally, parity errors.

## Interface
Parameters:
- `NB_DATA`, 8: data bits per frame.
- `NB_STOP`, 1: stop bits per frame; 1 or 2.
- `NB_TICK_COUNTER`, 4: oversample counter width; 16 ticks per bit.
- `NB_DATA_COUNTER`, 3: bit-index counter width; `$clog2(NB_DATA)`.

Ports:
- `i_clock` input, 1: system clock; all logic is on the rising edge.
- `i_reset` input, 1: synchronous reset, active-low.
- `i_tick` input, 1: one-clock oversample strobe from `baudrate_generator`, at 16× the baud rate.
- `i_data` input, 1: serial line; idles high.
- `o_data` output, NB_DATA: last received byte; held until the next frame completes.
- `o_data_valid` output, 1: one-clock strobe; `o_data` and the error flags are valid in this cycle.
- `o_frame_error` output, 1: stop bit was sampled low in the last frame.
- `o_parity_error` output, 1: parity mismatch in the last frame. Constant 0 when parity is compiled out.

## Operation
- All state advances only on clocks where `i_tick`=1, except the IDLE→START and BREAK→IDLE checks.
- Those two checks sample `i_data` on every clock.
- **IDLE**
  - Tick counter is held at 0.
  - `i_data`=0 → START.
- **START**
  - Counts ticks.
  - On the 8th tick (count==7), mid-start-bit:
    - If `i_data`=0: clear the counter and go to DATA.
    - If `i_data`=1: treat it as a glitch and return to IDLE. No strobe is issued.
- **DATA**
  - On the 16th tick of each bit (count==15), sample `i_data` into the shift register MSB.
  - Shift right, so the byte is assembled LSB first.
  - Clear the counter and increment the bit index.
  - After bit NB_DATA-1, go to PARITY (if compiled in), otherwise to STOP.
- **PARITY**
  - One bit period; sample at count==15.
  - Compare against the even parity of the received byte.
- **STOP**
  - NB_STOP bit periods; sample each at count==15.
  - Any low sample sets the pending frame error.
  - After the last stop sample, load `o_data`, the error flags and `o_data_valid`=1.
  - No error → IDLE. Frame error → BREAK.
- **BREAK**
  - Waits until `i_data`=1, then goes to IDLE.
  - Prevents a held-low line from producing repeated frames.
- Error flags are updated only together with `o_data_valid`. They hold their value until the next strobe.

## Timing
- Reset (`i_reset`=0 on a rising edge):
  - State returns to IDLE and counters clear.
  - `o_data`=0, `o_data_valid`=0, `o_frame_error`=0, `o_parity_error`=0.
- Reset mid-frame: the partial frame is discarded and no strobe is issued. After reset the block waits in IDLE for a falling edge.
- Start detection: the state is START one clock after `i_data` is sampled low.
- Latency from START entry to `o_data_valid`: 8 + 16·NB_DATA (+16 with parity) + 16·NB_STOP ticks.
  - `o_data_valid` rises on the clock after the final stop-sample tick.
  - 8N1 example: 152 ticks.
- `o_data_valid` is high for exactly one clock per frame.
- The next start bit is detectable on the clock after the strobe, so back-to-back frames with no idle gap are received.
- If `i_tick` and the start edge occur in the same clock, that tick is not counted in START.
- Counter wrap: the tick counter rolls from 15 to 0 only at a sample point. It never free-runs in IDLE or BREAK.

## Configuration
- `UART_RX_PARITY_EN`:
  - Defined: frame is 8E1.
    - PARITY state is present and the frame adds one bit period.
    - `o_parity_error` is set when the XOR of the data bits and the parity bit is 1.
  - Undefined: frame is 8N1.
    - PARITY state is absent.
    - `o_parity_error` is tied to 0.

## Test plan
- Reset with line high, then send 0xA5 as an 8N1 frame at 16 ticks per bit → one `o_data_valid` pulse, `o_data`=0xA5, both error flags 0, 152 ticks after START entry.
- Low glitch of 4 ticks on an idle line → no strobe, state back in IDLE. A following valid 0x3C frame → `o_data`=0x3C.
- 0x55 frame with the stop bit driven low, then line held low for 40 ticks, then released high → exactly one strobe with `o_data`=0x55 and `o_frame_error`=1, followed by no further strobes until a new start bit.
- Back-to-back 0x00 then 0xFF with no idle gap → two strobes 160 ticks apart, with the correct bytes and no errors.
- Assert `i_reset`=0 for one clock during data bit 4 of a frame → no strobe, all outputs 0. The next full 0x81 frame → `o_data`=0x81.
- With `UART_RX_PARITY_EN` defined: 0x03 sent with parity bit 1 → `o_parity_error`=1. 0x03 sent with parity bit 0 → `o_parity_error`=0. Latency is 168 ticks.
